wr_ptr_ctrl_sync: RTL and testbench

Write-side pointer controller for the dual-clock UART/ALU FIFO. It sits directly upstream of the read-side pointer controller and feeds it.
- Maintains the binary write pointer and drives memory write enable and address.
- Publishes a registered Gray-coded write pointer for the read domain.
- Synchronizes the read domain's Gray pointer into clk.
- Derives full, almost_full, fill level and a sticky overflow flag.

---
 rtl/wr_ptr_ctrl_sync_if.sv | 29 ++
 rtl/wr_ptr_ctrl_sync.sv | 77 +++++++
 tb/tb_wr_ptr_ctrl_sync.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/wr_ptr_ctrl_sync_if.sv
// Write-side FIFO pointer bundle: producer handshake, memory port, status and Gray pointer crossing.
// The master drives the producer and read-domain inputs; the slave is the write pointer controller.
interface wr_ptr_ctrl_sync_if #(
    parameter int ADDR_W = 3
);
    logic              write;
    logic              clear_overflow;
    logic [ADDR_W:0]   gray_rd_ptr;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   bin_wr_ptr;
    logic [ADDR_W:0]   gray_wr_ptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;

    modport master (
        output write, clear_overflow, gray_rd_ptr,
        input  mem_we, wr_addr, bin_wr_ptr, gray_wr_ptr,
        input  full, almost_full, fill_level, overflow
    );

    modport slave (
        input  write, clear_overflow, gray_rd_ptr,
        output mem_we, wr_addr, bin_wr_ptr, gray_wr_ptr,
        output full, almost_full, fill_level, overflow
    );
endinterface

// File: rtl/wr_ptr_ctrl_sync.sv
// Write-domain FIFO pointer controller: mem_we same cycle, gray_wr_ptr 1 edge after accept,
// read pointer seen after SYNC_STAGES edges; writes while full are dropped and flagged in sticky overflow.
module wr_ptr_ctrl_sync #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 1
) (
    input  logic               clk,
    input  logic               reset,
    wr_ptr_ctrl_sync_if.slave  wr_if
);
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(1 << ADDR_W);
    localparam logic [PTR_W-1:0] AF_THR  = PTR_W'((1 << ADDR_W) - AF_MARGIN);

    logic [PTR_W-1:0] r_bin_wr_ptr;
    logic [PTR_W-1:0] r_gray_wr_ptr;
    logic [PTR_W-1:0] r_sync [SYNC_STAGES];
    logic             r_overflow;

    logic [PTR_W-1:0] w_rd_gray_sync;
    logic [PTR_W-1:0] w_rd_bin_sync;
    logic [PTR_W-1:0] w_fill;
    logic [PTR_W-1:0] w_bin_next;
    logic             w_full;
    logic             w_accept;

    assign w_rd_gray_sync = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_rd_bin_sync = '0;
        for (int i = 0; i < PTR_W; i++) begin
            w_rd_bin_sync[i] = ^(w_rd_gray_sync >> i);
        end
    end

    assign w_fill     = r_bin_wr_ptr - w_rd_bin_sync;
    assign w_full     = (w_fill == DEPTH_V);
    assign w_accept   = wr_if.write & ~w_full;
    assign w_bin_next = r_bin_wr_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bin_wr_ptr  <= '0;
            r_gray_wr_ptr <= '0;
            r_overflow    <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= wr_if.gray_rd_ptr;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            // Gray copy is registered from the next binary value so the crossing sees one-bit steps only.
            if (w_accept) begin
                r_bin_wr_ptr  <= w_bin_next;
                r_gray_wr_ptr <= w_bin_next ^ (w_bin_next >> 1);
            end
            if (wr_if.write && w_full) begin
                r_overflow <= 1'b1;
            end else if (wr_if.clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign wr_if.mem_we      = w_accept;
    assign wr_if.wr_addr     = r_bin_wr_ptr[ADDR_W-1:0];
    assign wr_if.bin_wr_ptr  = r_bin_wr_ptr;
    assign wr_if.gray_wr_ptr = r_gray_wr_ptr;
    assign wr_if.full        = w_full;
    assign wr_if.almost_full = (w_fill >= AF_THR);
    assign wr_if.fill_level  = w_fill;
    assign wr_if.overflow    = r_overflow;
endmodule

// File: tb/tb_wr_ptr_ctrl_sync.sv
// Bench for wr_ptr_ctrl_sync: a count-based model (writes accepted, reader count delayed by the
// synchronizer depth) is compared on every falling edge, plus literal checks from the test plan.
module tb_wr_ptr_ctrl_sync;
    localparam int ADDR_W = 3;
    localparam int SYNC   = 2;
    localparam int AFM    = 1;
    localparam int PW     = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PMOD   = 1 << PW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wr_ptr_ctrl_sync_if #(.ADDR_W(ADDR_W)) bus ();

    wr_ptr_ctrl_sync #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AF_MARGIN(AFM)) dut (
        .clk   (clk),
        .reset (reset),
        .wr_if (bus)
    );

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    bit chk_en   = 0;

    int m_wr  = 0;
    int m_ovf = 0;
    int m_seen [SYNC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_fill();
        return (m_wr - m_seen[SYNC-1] + PMOD) % PMOD;
    endfunction

    task automatic set_rd(input int n);
        rd_cnt = n % PMOD;
        bus.gray_rd_ptr = PW'(rd_cnt ^ (rd_cnt >> 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: counts accepted writes; the reader's count becomes visible SYNC edges later.
    always @(posedge clk) begin : mdl
        bit f;
        if (!reset) begin
            m_wr  = 0;
            m_ovf = 0;
            for (int s = 0; s < SYNC; s++) m_seen[s] = 0;
        end else begin
            f = (m_fill() == DEPTH);
            if (bus.write && !f) m_wr = (m_wr + 1) % PMOD;
            if (bus.write && f) m_ovf = 1;
            else if (bus.clear_overflow) m_ovf = 0;
            for (int s = SYNC - 1; s > 0; s--) m_seen[s] = m_seen[s-1];
            m_seen[0] = rd_cnt;
        end
    end

    always @(negedge clk) begin : cmp
        int f;
        if (chk_en) begin
            f = m_fill();
            chk("bin_wr_ptr",  32'(bus.bin_wr_ptr),  32'(m_wr));
            chk("gray_wr_ptr", 32'(bus.gray_wr_ptr), 32'(m_wr ^ (m_wr >> 1)));
            chk("fill_level",  32'(bus.fill_level),  32'(f));
            chk("full",        32'(bus.full),        32'(f == DEPTH));
            chk("almost_full", 32'(bus.almost_full), 32'(f >= DEPTH - AFM));
            chk("mem_we",      32'(bus.mem_we),      32'(bus.write && (f != DEPTH)));
            chk("wr_addr",     32'(bus.wr_addr),     32'(m_wr % DEPTH));
            chk("overflow",    32'(bus.overflow),    32'(m_ovf));
        end
    end

    logic [3:0] gseq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    initial begin
        reset = 1'b0;
        bus.write = 1'b1;
        bus.clear_overflow = 1'b0;
        set_rd(0);
        step();
        chk_en = 1;
        step();
        chk("rst_bin",    32'(bus.bin_wr_ptr),  32'd0);
        chk("rst_gray",   32'(bus.gray_wr_ptr), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we),      32'd1);
        chk("rst_full",   32'(bus.full),        32'd0);
        chk("rst_ovf",    32'(bus.overflow),    32'd0);

        // Fill from empty to full
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fill_gray", 32'(bus.gray_wr_ptr), 32'(gseq[i]));
            if (i == 6) begin
                chk("fill7_af",   32'(bus.almost_full), 32'd1);
                chk("fill7_full", 32'(bus.full),        32'd0);
            end
        end
        chk("full_flag",   32'(bus.full),       32'd1);
        chk("full_bin",    32'(bus.bin_wr_ptr), 32'd8);
        chk("full_mem_we", 32'(bus.mem_we),     32'd0);

        // Overflow set / clear / set-wins
        step();
        chk("ovf_bin", 32'(bus.bin_wr_ptr), 32'd8);
        chk("ovf_set", 32'(bus.overflow),   32'd1);
        bus.write = 1'b0;
        bus.clear_overflow = 1'b1;
        step();
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        bus.write = 1'b1;
        step();
        chk("ovf_setwins", 32'(bus.overflow), 32'd1);
        bus.write = 1'b0;
        bus.clear_overflow = 1'b0;

        // Read pointer crossing latency
        set_rd(1);
        step();
        chk("sync_full_e1", 32'(bus.full), 32'd1);
        step();
        chk("sync_full_e2", 32'(bus.full),       32'd0);
        chk("sync_fill",    32'(bus.fill_level), 32'd7);
        bus.write = 1'b1;
        #1;
        chk("sync_we",   32'(bus.mem_we),  32'd1);
        chk("sync_addr", 32'(bus.wr_addr), 32'd0);
        step();
        chk("sync_bin", 32'(bus.bin_wr_ptr), 32'd9);
        bus.write = 1'b0;

        // Reset clears a set overflow
        reset = 1'b0;
        set_rd(0);
        step();
        chk("rst2_ovf", 32'(bus.overflow),   32'd0);
        chk("rst2_bin", 32'(bus.bin_wr_ptr), 32'd0);
        reset = 1'b1;

        // Wrap with reader trailing two writes behind
        bus.write = 1'b1;
        for (int n = 0; n < 20; n++) begin
            set_rd(n >= 2 ? n - 2 : 0);
            step();
            chk("wrap_nofull", 32'(bus.full), 32'd0);
            if (n == 15) chk("wrap_zero", 32'(bus.bin_wr_ptr), 32'd0);
        end
        chk("wrap_final", 32'(bus.bin_wr_ptr), 32'd4);
        bus.write = 1'b0;
        set_rd(4);
        repeat (3) step();

        // Reset in the middle of a burst
        bus.write = 1'b1;
        repeat (5) step();
        reset = 1'b0;
        step();
        chk("mid_bin",  32'(bus.bin_wr_ptr),  32'd0);
        chk("mid_gray", 32'(bus.gray_wr_ptr), 32'd0);
        chk("mid_fill", 32'(bus.fill_level),  32'd0);
        chk("mid_ovf",  32'(bus.overflow),    32'd0);
        reset = 1'b1;
        set_rd(0);
        #1;
        chk("mid_we",   32'(bus.mem_we),  32'd1);
        chk("mid_addr", 32'(bus.wr_addr), 32'd0);
        step();
        chk("mid_bin1", 32'(bus.bin_wr_ptr), 32'd1);
        bus.write = 1'b0;
        repeat (3) step();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
